// File: rtl/ervp_sram_cell_arbiter_pkg.sv
// Shared definitions for the SRAM cell arbiter.
//   rsp_state_e   : per-requester read-response state (EMPTY/INFLIGHT/HELD)
//   RSP_STATE_W   : width of the response-state encoding
//   calc_num_byte : bytes per data word (data width must be a multiple of 8)
package ervp_sram_cell_arbiter_pkg;

  localparam int RSP_STATE_W = 2;

  typedef enum logic [RSP_STATE_W-1:0] {
    RSP_EMPTY    = 2'd0,
    RSP_INFLIGHT = 2'd1,
    RSP_HELD     = 2'd2
  } rsp_state_e;

  function automatic int calc_num_byte(input int bw_data);
    return bw_data / 8;
  endfunction

endpackage

// File: rtl/ervp_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clk, rstnn : clock, async active-low reset
//   elig_list  : per-requester eligibility
//   lock_list  : per-requester lock request (used only with SRAM_CELL_ARBITER_LOCK_EN)
//   grant_list : one-hot grant, combinational from elig_list
// The pointer holds the last winner; search starts one past it. Reset puts the
// pointer on NUM_REQ-1 so requester 0 is first.
// With SRAM_CELL_ARBITER_LOCK_EN defined, a winner presenting lock=1 keeps
// exclusive access until it is granted with lock=0; while the holder is not
// eligible nobody is granted.
module ervp_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic [NUM_REQ-1:0] elig_list,
  input  logic [NUM_REQ-1:0] lock_list,
  output logic [NUM_REQ-1:0] grant_list
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] rr_grant;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_found;
  logic [PTR_W-1:0]   gnt_idx;

  // One extra bit on the candidate so ptr+i cannot wrap before the modulo.
  always_comb begin
    logic [PTR_W:0] cand;
    rr_grant = '0;
    rr_idx   = ptr;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!rr_found && elig_list[cand[PTR_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[PTR_W-1:0];
      end
    end
    if (rr_found) rr_grant[rr_idx] = 1'b1;
  end

`ifdef SRAM_CELL_ARBITER_LOCK_EN
  logic             lock_active;
  logic [PTR_W-1:0] lock_owner;

  always_comb begin
    grant_list = rr_grant;
    gnt_idx    = rr_idx;
    if (lock_active) begin
      grant_list = '0;
      gnt_idx    = lock_owner;
      if (elig_list[lock_owner]) grant_list[lock_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (|grant_list) begin
      lock_active <= lock_list[gnt_idx];
      lock_owner  <= gnt_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_list;
  assign grant_list  = rr_grant;
  assign gnt_idx     = rr_idx;
`endif

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)           ptr <= PTR_W'(NUM_REQ-1);
    else if (|grant_list) ptr <= gnt_idx;
  end

endmodule

// File: rtl/ervp_sram_cell_arbiter.sv
// Shares one single-port SRAM cell (1-cycle read latency) among NUM_REQ
// requesters with round-robin arbitration and a 1-entry skid buffer per
// requester so read data survives response back-pressure.
// Optional feature macro: SRAM_CELL_ARBITER_LOCK_EN (grant locking).
// Ports:
//   clk, rstnn               : clock, async active-low reset
//   req_*_list               : per-requester request channel (flattened, slice k = requester k)
//   rsp_*_list               : per-requester read-response channel
//   cell_*                   : SRAM macro interface; cell_rdata valid the cycle after a read
module ervp_sram_cell_arbiter
  import ervp_sram_cell_arbiter_pkg::*;
#(
  parameter int BW_DATA  = 32,
  parameter int BW_INDEX = 10,
  parameter int NUM_REQ  = 2,
  localparam int NUM_BYTE = calc_num_byte(BW_DATA)
) (
  input  logic                         clk,
  input  logic                         rstnn,
  input  logic [NUM_REQ-1:0]           req_valid_list,
  output logic [NUM_REQ-1:0]           req_ready_list,
  input  logic [NUM_REQ-1:0]           req_write_list,
  input  logic [BW_INDEX*NUM_REQ-1:0]  req_index_list,
  input  logic [NUM_BYTE*NUM_REQ-1:0]  req_wstrb_list,
  input  logic [BW_DATA*NUM_REQ-1:0]   req_wdata_list,
  input  logic [NUM_REQ-1:0]           req_lock_list,
  output logic [NUM_REQ-1:0]           rsp_valid_list,
  input  logic [NUM_REQ-1:0]           rsp_ready_list,
  output logic [BW_DATA*NUM_REQ-1:0]   rsp_rdata_list,
  output logic                         cell_enable,
  output logic                         cell_write_enable,
  output logic [BW_INDEX-1:0]          cell_index,
  output logic [NUM_BYTE-1:0]          cell_write_enable_byte,
  output logic [BW_DATA-1:0]           cell_wdata,
  input  logic [BW_DATA-1:0]           cell_rdata
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;

  ervp_rr_arbiter #(.NUM_REQ(NUM_REQ)) i_rr_arbiter (
    .clk        (clk),
    .rstnn      (rstnn),
    .elig_list  (elig),
    .lock_list  (req_lock_list),
    .grant_list (grant)
  );

  assign req_ready_list = grant;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    rsp_state_e         state;
    logic [BW_DATA-1:0] hold;
    logic               rd_grant;

    assign rd_grant = grant[k] & ~req_write_list[k];

    // A read may only issue when its response slot is free or being drained
    // this cycle; rstnn gating keeps every output quiet during reset.
    assign elig[k] = rstnn & req_valid_list[k] &
                     (req_write_list[k] | (state == RSP_EMPTY) | rsp_ready_list[k]);

    always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
        state <= RSP_EMPTY;
        hold  <= '0;
      end else begin
        case (state)
          RSP_INFLIGHT: begin
            if (rsp_ready_list[k]) state <= RSP_EMPTY;
            else begin
              state <= RSP_HELD;
              hold  <= cell_rdata;  // SRAM output is only valid this one cycle
            end
          end
          RSP_HELD: if (rsp_ready_list[k]) state <= RSP_EMPTY;
          default:  state <= RSP_EMPTY;
        endcase
        if (rd_grant) state <= RSP_INFLIGHT;
      end
    end

    assign rsp_valid_list[k] = (state != RSP_EMPTY);
    assign rsp_rdata_list[k*BW_DATA +: BW_DATA] =
      (state == RSP_INFLIGHT) ? cell_rdata :
      (state == RSP_HELD)     ? hold       : '0;
  end

  // Grant is one-hot, so the winner's fields are simply selected.
  always_comb begin
    cell_enable            = |grant;
    cell_write_enable      = 1'b0;
    cell_index             = '0;
    cell_write_enable_byte = '0;
    cell_wdata             = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        cell_write_enable      = req_write_list[k];
        cell_index             = req_index_list[k*BW_INDEX +: BW_INDEX];
        cell_write_enable_byte = req_write_list[k] ? req_wstrb_list[k*NUM_BYTE +: NUM_BYTE] : '0;
        cell_wdata             = req_wdata_list[k*BW_DATA +: BW_DATA];
      end
    end
  end

endmodule

// File: tb/tb_ervp_sram_cell_arbiter.sv
module tb_ervp_sram_cell_arbiter;
  localparam int BW_DATA  = 32;
  localparam int BW_INDEX = 10;
  localparam int NUM_REQ  = 2;
  localparam int NUM_BYTE = BW_DATA / 8;
  localparam int DEPTH    = 1 << BW_INDEX;

  logic                        clk = 1'b0;
  logic                        rstnn = 1'b0;
  logic [NUM_REQ-1:0]          req_valid_list = '0;
  logic [NUM_REQ-1:0]          req_ready_list;
  logic [NUM_REQ-1:0]          req_write_list = '0;
  logic [BW_INDEX*NUM_REQ-1:0] req_index_list = '0;
  logic [NUM_BYTE*NUM_REQ-1:0] req_wstrb_list = '0;
  logic [BW_DATA*NUM_REQ-1:0]  req_wdata_list = '0;
  logic [NUM_REQ-1:0]          req_lock_list = '0;
  logic [NUM_REQ-1:0]          rsp_valid_list;
  logic [NUM_REQ-1:0]          rsp_ready_list = '1;
  logic [BW_DATA*NUM_REQ-1:0]  rsp_rdata_list;
  logic                        cell_enable;
  logic                        cell_write_enable;
  logic [BW_INDEX-1:0]         cell_index;
  logic [NUM_BYTE-1:0]         cell_write_enable_byte;
  logic [BW_DATA-1:0]          cell_wdata;
  logic [BW_DATA-1:0]          cell_rdata = '0;

  int checks = 0;
  int errors = 0;

  ervp_sram_cell_arbiter #(.BW_DATA(BW_DATA), .BW_INDEX(BW_INDEX), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rstnn(rstnn),
    .req_valid_list(req_valid_list), .req_ready_list(req_ready_list),
    .req_write_list(req_write_list), .req_index_list(req_index_list),
    .req_wstrb_list(req_wstrb_list), .req_wdata_list(req_wdata_list),
    .req_lock_list(req_lock_list),
    .rsp_valid_list(rsp_valid_list), .rsp_ready_list(rsp_ready_list),
    .rsp_rdata_list(rsp_rdata_list),
    .cell_enable(cell_enable), .cell_write_enable(cell_write_enable),
    .cell_index(cell_index), .cell_write_enable_byte(cell_write_enable_byte),
    .cell_wdata(cell_wdata), .cell_rdata(cell_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] st);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < NUM_BYTE; b++) if (st[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  // SRAM macro emulation driven only by the DUT's cell outputs; read data is
  // garbage except the cycle after a read.
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (cell_enable && cell_write_enable)
      sram[cell_index] <= merge(sram[cell_index], cell_wdata, cell_write_enable_byte);
    if (cell_enable && !cell_write_enable) cell_rdata <= sram[cell_index];
    else                                   cell_rdata <= $urandom;
  end

  // Behavioural model: a pending-response flag and its expected data per
  // requester, the memory as the requesters should see it, the last winner,
  // and the lock holder.
  logic [31:0] mmem [DEPTH];
  bit          pend  [NUM_REQ];
  logic [31:0] pdata [NUM_REQ];
  int          last  = NUM_REQ - 1;
  int          owner = -1;

  function automatic logic [31:0] rsp_of(input int k);
    return rsp_rdata_list[k*BW_DATA +: BW_DATA];
  endfunction

  always @(negedge clk) begin
    if (!rstnn) begin
      chk("rst_req_ready", 64'(req_ready_list), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_list), 64'(0));
      chk("rst_cell", {cell_enable, cell_write_enable, cell_index, cell_write_enable_byte, cell_wdata}, 64'(0));
      for (int k = 0; k < NUM_REQ; k++) pend[k] = 0;
      last  = NUM_REQ - 1;
      owner = -1;
    end else begin
      bit [NUM_REQ-1:0] el;
      int win;
      logic [NUM_REQ-1:0] exp_rdy;
      int idx;
      for (int k = 0; k < NUM_REQ; k++)
        el[k] = req_valid_list[k] && (req_write_list[k] || !pend[k] || rsp_ready_list[k]);
      win = -1;
      if (owner >= 0) begin
        if (el[owner]) win = owner;
      end else begin
        for (int i = 1; i <= NUM_REQ; i++)
          if (win < 0 && el[(last + i) % NUM_REQ]) win = (last + i) % NUM_REQ;
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 64'(req_ready_list), 64'(exp_rdy));
      for (int k = 0; k < NUM_REQ; k++) begin
        chk("rsp_valid", 64'(rsp_valid_list[k]), 64'(pend[k]));
        if (pend[k]) chk("rsp_rdata", 64'(rsp_of(k)), 64'(pdata[k]));
      end
      if (win >= 0) begin
        idx = int'(req_index_list[win*BW_INDEX +: BW_INDEX]);
        chk("cell_enable", 64'(cell_enable), 64'(1));
        chk("cell_we", 64'(cell_write_enable), 64'(req_write_list[win]));
        chk("cell_index", 64'(cell_index), 64'(idx));
        chk("cell_wdata", 64'(cell_wdata), 64'(req_wdata_list[win*BW_DATA +: BW_DATA]));
        chk("cell_web", 64'(cell_write_enable_byte),
            req_write_list[win] ? 64'(req_wstrb_list[win*NUM_BYTE +: NUM_BYTE]) : 64'(0));
      end else begin
        chk("cell_idle", {cell_enable, cell_write_enable, cell_index, cell_write_enable_byte, cell_wdata}, 64'(0));
      end
      for (int k = 0; k < NUM_REQ; k++) if (pend[k] && rsp_ready_list[k]) pend[k] = 0;
      if (win >= 0) begin
        if (req_write_list[win])
          mmem[idx] = merge(mmem[idx], req_wdata_list[win*BW_DATA +: BW_DATA],
                            req_wstrb_list[win*NUM_BYTE +: NUM_BYTE]);
        else begin
          pend[win]  = 1;
          pdata[win] = mmem[idx];
        end
        last = win;
`ifdef SRAM_CELL_ARBITER_LOCK_EN
        owner = req_lock_list[win] ? win : -1;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input bit w, input int idx,
                         input logic [3:0] st, input logic [31:0] d, input bit lk);
    req_valid_list[k] = v;
    req_write_list[k] = w;
    req_index_list[k*BW_INDEX +: BW_INDEX] = BW_INDEX'(idx);
    req_wstrb_list[k*NUM_BYTE +: NUM_BYTE] = st;
    req_wdata_list[k*BW_DATA +: BW_DATA] = d;
    req_lock_list[k] = lk;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 0, 0, 0, 4'h0, 32'h0, 0);
    rsp_ready_list = '1;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      sram[i] = v;
      mmem[i] = v;
    end
    sram[5] = 32'hA5A5_0001; mmem[5] = 32'hA5A5_0001;
    sram[7] = 32'h0000_0077; mmem[7] = 32'h0000_0077;
    sram[9] = 32'h0000_0099; mmem[9] = 32'h0000_0099;
    sram[3] = 32'hFFFF_FFFF; mmem[3] = 32'hFFFF_FFFF;

    repeat (3) tick();
    rstnn = 1'b1;
    tick();

    // Single read
    set_req(0, 1, 0, 5, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("single_grant", {cell_enable, 6'(cell_index), 2'(req_ready_list)}, {1'b1, 6'd5, 2'b01});
    tick(); idle_all();
    @(negedge clk);
    chk("single_rsp", {rsp_valid_list[0], rsp_of(0)}, {1'b1, 32'hA5A5_0001});
    tick();
    @(negedge clk);
    chk("single_empty", 64'(rsp_valid_list[0]), 64'(0));

    // Back-pressure on requester 1
    tick();
    set_req(1, 1, 0, 7, 4'h0, 32'h0, 0);
    rsp_ready_list[1] = 1'b0;
    @(negedge clk);
    chk("bp_grant", 64'(req_ready_list), 64'(2'b10));
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c < 2) set_req(1, 1, 0, 9, 4'h0, 32'h0, 0);
      else       set_req(1, 1, 1, 100, 4'hF, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      chk("bp_hold", {rsp_valid_list[1], rsp_of(1)}, {1'b1, 32'h0000_0077});
      chk("bp_ready", 64'(req_ready_list[1]), (c < 2) ? 64'(0) : 64'(1));
    end
    tick();
    set_req(1, 1, 0, 9, 4'h0, 32'h0, 0);
    rsp_ready_list[1] = 1'b1;
    @(negedge clk);
    chk("bp_release", {req_ready_list[1], rsp_of(1)}, {1'b1, 32'h0000_0077});
    tick(); idle_all();
    @(negedge clk);
    chk("bp_next", {rsp_valid_list[1], rsp_of(1)}, {1'b1, 32'h0000_0099});

    // Byte write then readback
    tick();
    set_req(0, 1, 1, 3, 4'b0010, 32'h1122_3344, 0);
    @(negedge clk);
    chk("bw_strobe", {cell_write_enable, 4'(cell_write_enable_byte)}, {1'b1, 4'b0010});
    tick();
    set_req(0, 1, 0, 3, 4'h0, 32'h0, 0);
    tick(); idle_all();
    @(negedge clk);
    chk("bw_readback", 64'(rsp_of(0)), 64'(32'hFFFF_33FF));

    // Reset during an in-flight read, then contention from reset
    tick();
    set_req(0, 1, 0, 5, 4'h0, 32'h0, 0);
    tick();
    rstnn = 1'b0;
    set_req(0, 1, 0, 1, 4'h0, 32'h0, 0);
    set_req(1, 1, 0, 2, 4'h0, 32'h0, 0);
    @(negedge clk);
    chk("rst_mid", {rsp_valid_list, cell_enable, req_ready_list}, 64'(0));
    tick();
    rstnn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      chk("contention", 64'(req_ready_list), (c % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
    end
    tick(); idle_all();

`ifdef SRAM_CELL_ARBITER_LOCK_EN
    tick();
    rstnn = 1'b0;
    tick();
    rstnn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      set_req(0, 1, 0, 10 + c, 4'h0, 32'h0, (c < 3));
      set_req(1, 1, 0, 20, 4'h0, 32'h0, 0);
      @(negedge clk);
      chk("lock_seq", 64'(req_ready_list), (c < 4) ? 64'(2'b01) : 64'(2'b10));
    end
    tick(); idle_all();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rstnn = (c != 1500);
      for (int k = 0; k < NUM_REQ; k++) begin
        set_req(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 15)), 4'($urandom), $urandom,
                ($urandom_range(0, 3) == 0));
        rsp_ready_list[k] = ($urandom_range(0, 3) != 0);
      end
    end
    tick(); idle_all();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ervp_sram_cell_arbiter.md
Name: ervp_sram_cell_arbiter

Overview:
- Shares one single-port SRAM cell (1-cycle read latency) between NUM_REQ requesters, e.g. the AXI SRAM controller and an accelerator/DMA engine.
- Round-robin grant; each requester has a valid/ready request channel and a valid/ready read-response channel.
- Each requester has a 1-entry skid response buffer, so read data is never lost under back-pressure.
- Sits between the requesters' cell-style buses and the physical SRAM macro wrapper.

Parameters:
- BW_DATA, 32, data width in bits; must be a multiple of 8.
- BW_INDEX, 10, cell word-index width.
- NUM_REQ, 2, number of requesters (range 2..8).
- NUM_BYTE, BW_DATA/8, derived constant; not overridable.

Ports:
- clk  in  1  clock
- rstnn  in  1  reset, asynchronous, active-low
- req_valid_list  in  NUM_REQ  per-requester access request
- req_ready_list  out  NUM_REQ  request accepted (grant) this cycle
- req_write_list  in  NUM_REQ  1 = write, 0 = read
- req_index_list  in  BW_INDEX*NUM_REQ  word index, flattened; requester k occupies slice k
- req_wstrb_list  in  NUM_BYTE*NUM_REQ  byte write strobes
- req_wdata_list  in  BW_DATA*NUM_REQ  write data
- req_lock_list  in  NUM_REQ  hold grant (only with lock feature)
- rsp_valid_list  out  NUM_REQ  read data valid
- rsp_ready_list  in  NUM_REQ  read data accepted
- rsp_rdata_list  out  BW_DATA*NUM_REQ  read data
- cell_enable  out  1  SRAM access strobe
- cell_write_enable  out  1  SRAM write
- cell_index  out  BW_INDEX  SRAM word index
- cell_write_enable_byte  out  NUM_BYTE  byte enables
- cell_wdata  out  BW_DATA  SRAM write data
- cell_rdata  in  BW_DATA  SRAM read data; valid one cycle after a read enable only

Behaviour:
- Reset values: all outputs 0; all response states EMPTY; RR pointer = NUM_REQ-1, so requester 0 has first priority.
- Response state per requester: EMPTY, INFLIGHT, HELD.
  - INFLIGHT: the read was issued last cycle. rsp_valid=1 and rsp_rdata=cell_rdata (pass-through).
    - If rsp_ready=1: go to EMPTY.
    - If rsp_ready=0: capture cell_rdata into the hold register and go to HELD.
  - HELD: rsp_valid=1, rsp_rdata=hold register. On rsp_ready go to EMPTY.
  - A new grant for a read overrides the next state to INFLIGHT.
- Eligibility of requester k:
  - req_valid[k] must be 1, and one of the following must hold:
    - the request is a write, or
    - the response state is EMPTY, or
    - the response is being consumed this cycle (INFLIGHT or HELD, with rsp_ready[k]=1).
  - Writes are always eligible; they produce no response.
- Arbitration:
  - Combinational; at most one grant per cycle.
  - Search starts at pointer+1 modulo NUM_REQ; the first eligible requester wins.
  - req_ready[k] = grant[k]. The pointer updates to k on a grant; with no grant, the pointer holds.
- Cell drive (same cycle as the grant):
  - cell_enable = any grant.
  - cell_write_enable = grant & write.
  - cell_write_enable_byte = wstrb when writing, 0 otherwise.
  - cell_index and cell_wdata come from the winner.
  - With no grant, every cell output is 0.
- Latency:
  - Read: the grant is in cycle N and rsp_valid rises in N+1.
  - Back-to-back reads from one requester give 1 word/cycle while rsp_ready=1.
- Simultaneous events: a consume and a new read grant in the same cycle leave the requester INFLIGHT, with no bubble.
- Starvation: a requester that is eligible and not blocked by a lock is granted within NUM_REQ cycles.
- Reset mid-operation: in-flight reads are discarded and held data is lost. Requesters must reissue.

Optional Feature:
- Macro SRAM_CELL_ARBITER_LOCK_EN.
- Defined:
  - If the granted requester has req_lock=1, the next grant is restricted to that requester until it presents a request with lock=0 (that request is the last locked beat). This gives atomic read-modify-write and uninterrupted bursts.
  - While the lock holder is not eligible, no grant is issued to anyone.
- Undefined: req_lock_list is ignored and plain round-robin applies.

Decomposition:
- Shared package/header holds:
  - response-state encodings (EMPTY=0, INFLIGHT=1, HELD=2) and their width (2);
  - the NUM_BYTE derivation.
- One sub-module: ervp_rr_arbiter (NUM_REQ eligibility in, one-hot grant out, pointer register inside, lock input gated by the macro). It is reusable elsewhere.

Test Plan:
- Single read: req0 reads index 5 (SRAM[5]=0xA5A5_0001), rsp_ready0=1 -> cell_enable=1 in cycle N; rsp_valid0=1 with 0xA5A5_0001 in N+1; then EMPTY.
- Contention: req0 and req1 both read continuously with ready=1 -> grants alternate 0,1,0,1 from reset; each response arrives one cycle after its grant.
- Back-pressure: req1 reads index 7 (0x0000_0077), rsp_ready1 held 0 for 3 cycles -> rsp_valid1 stays 1 and data stays 0x0000_0077 while cell_rdata changes. req1 is not granted another read until ready=1, but its writes are still granted.
- Byte write: req0 writes index 3, wstrb=0b0010, wdata=0x1122_3344 over 0xFFFF_FFFF -> a readback gives 0xFFFF_33FF.
- Reset mid-read: assert rstnn=0 in the INFLIGHT cycle -> all rsp_valid=0, cell outputs 0, and req0 wins first after release.
- Lock (macro on): req0 issues 3 locked beats then an unlocked one while req1 requests -> req1 is granted only after req0's fourth beat.
